// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU decoder and the iterative ALU.
//   XLEN_DEFAULT : default operand/result width.
//   alu_op_t     : 5-bit operation code produced by the decoder.
//   is_muldiv()  : op runs on the iterative multiply/divide datapath.
//   is_div()     : op is one of the divide/remainder family.
package alu_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [4:0] {
      OP_ADD    = 5'd0,
      OP_SUB    = 5'd1,
      OP_SLL    = 5'd2,
      OP_SLT    = 5'd3,
      OP_SLTU   = 5'd4,
      OP_XOR    = 5'd5,
      OP_SRL    = 5'd6,
      OP_SRA    = 5'd7,
      OP_OR     = 5'd8,
      OP_AND    = 5'd9,
      OP_MUL    = 5'd16,
      OP_MULH   = 5'd17,
      OP_MULHSU = 5'd18,
      OP_MULHU  = 5'd19,
      OP_DIV    = 5'd20,
      OP_DIVU   = 5'd21,
      OP_REM    = 5'd22,
      OP_REMU   = 5'd23
   } alu_op_t;

   function automatic logic is_muldiv(alu_op_t op);
      logic r;
      case (op)
         OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
         OP_DIV, OP_DIVU, OP_REM, OP_REMU: r = 1'b1;
         default:                          r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic is_div(alu_op_t op);
      logic r;
      case (op)
         OP_DIV, OP_DIVU, OP_REM, OP_REMU: r = 1'b1;
         default:                          r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative multiply / divide datapath, one bit per cycle.
//   clk, rst     : clock, asynchronous active-high reset (aborts any operation).
//   start        : load op/op1/op2 this edge; XLEN step cycles follow.
//   op           : MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
//   op1, op2     : operands (captured on start).
//   done         : high during the final step cycle; result is valid with it.
//   result       : sign-corrected result, valid only while done is high.
// Divide-by-zero is never started here; the parent resolves it directly.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  alu_op_t         op,
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int SHW   = $clog2(XLEN);
   localparam int CNT_W = SHW + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   logic            active_q,   active_d;
   logic [SHW:0]    cnt_q,      cnt_d;
   logic            is_mul_q,   is_mul_d;
   logic            take_hi_q,  take_hi_d;   // MULH*: high half; DIV family: remainder
   logic            neg_main_q, neg_main_d;  // product / quotient sign
   logic            neg_rem_q,  neg_rem_d;   // remainder sign (dividend sign)
   logic [XLEN-1:0] mcand_q,    mcand_d;     // multiplicand or divisor magnitude
   logic [XLEN-1:0] hi_q,       hi_d;        // product high half or partial remainder
   logic [XLEN-1:0] lo_q,       lo_d;        // multiplier/product low, or dividend/quotient

   logic              a_signed, b_signed, a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [XLEN:0]     add_sum, rem_sh, rem_diff;
   logic              q_bit;
   logic [XLEN-1:0]   step_hi, step_lo;
   logic [2*XLEN-1:0] prod, prod_fix;

   always_comb begin
      active_d   = active_q;
      cnt_d      = cnt_q;
      is_mul_d   = is_mul_q;
      take_hi_d  = take_hi_q;
      neg_main_d = neg_main_q;
      neg_rem_d  = neg_rem_q;
      mcand_d    = mcand_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done       = 1'b0;
      result     = '0;

      a_signed = 1'b0;
      b_signed = 1'b0;
      case (op)
         OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
            a_signed = 1'b1;
            b_signed = 1'b1;
         end
         OP_MULHSU: a_signed = 1'b1;
         default: ;
      endcase
      a_neg = a_signed & op1[XLEN-1];
      b_neg = b_signed & op2[XLEN-1];
      a_mag = a_neg ? -op1 : op1;
      b_mag = b_neg ? -op2 : op2;

      // Shift-add multiply step: add multiplicand when the current
      // multiplier bit is set, then shift the {hi,lo} pair right by one.
      add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);

      // Restoring divide step: bring the next dividend bit into the
      // remainder, subtract the divisor, keep the difference if non-negative.
      rem_sh   = {hi_q, lo_q[XLEN-1]};
      rem_diff = rem_sh - {1'b0, mcand_q};
      q_bit    = ~rem_diff[XLEN];

      if (is_mul_q) begin
         step_hi = add_sum[XLEN:1];
         step_lo = {add_sum[0], lo_q[XLEN-1:1]};
      end else begin
         step_hi = q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
         step_lo = {lo_q[XLEN-2:0], q_bit};
      end

      prod     = {step_hi, step_lo};
      prod_fix = neg_main_q ? -prod : prod;

      if (start) begin
         active_d   = 1'b1;
         cnt_d      = '0;
         is_mul_d   = ~is_div(op);
         take_hi_d  = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU) ||
                      (op == OP_REM)  || (op == OP_REMU);
         neg_main_d = a_neg ^ b_neg;
         neg_rem_d  = a_neg;
         hi_d       = '0;
         if (is_div(op)) begin
            mcand_d = b_mag;
            lo_d    = a_mag;
         end else begin
            mcand_d = a_mag;
            lo_d    = b_mag;
         end
      end else if (active_q) begin
         hi_d  = step_hi;
         lo_d  = step_lo;
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CNT_LAST) begin
            done     = 1'b1;
            active_d = 1'b0;
            cnt_d    = '0;
            if (is_mul_q) begin
               result = take_hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
            end else if (take_hi_q) begin
               result = neg_rem_q ? -step_hi : step_hi;
            end else begin
               result = neg_main_q ? -step_lo : step_lo;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_q   <= 1'b0;
         cnt_q      <= '0;
         is_mul_q   <= 1'b0;
         take_hi_q  <= 1'b0;
         neg_main_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         mcand_q    <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         active_q   <= active_d;
         cnt_q      <= cnt_d;
         is_mul_q   <= is_mul_d;
         take_hi_q  <= take_hi_d;
         neg_main_q <= neg_main_d;
         neg_rem_q  <= neg_rem_d;
         mcand_q    <= mcand_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

endmodule

// File: rtl/alu_iter.sv
// alu_iter: ALU with single-cycle ops and an iterative multiply/divide unit.
//   clk, rst            : clock, asynchronous active-high reset.
//   in_valid / in_ready : request handshake; a request (op, op1, op2) is taken
//                         on a rising edge where both are high. in_ready is
//                         high only in IDLE, so nothing is queued while busy.
//   op, op1, op2        : operation and operands.
//   out_valid/out_ready : result handshake; result is held in DONE until both
//                         are high on an edge, which returns the unit to IDLE.
//   result              : registered result.
//   busy                : state is not IDLE.
// Latency: 1 cycle for single-cycle ops, divide-by-zero and unknown codes;
// XLEN+1 cycles for multiply/divide.
module alu_iter
   import alu_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  alu_op_t         op,
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int SHW = $clog2(XLEN);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]      state_q,  state_d;
   logic [XLEN-1:0] result_q, result_d;

   logic            md_start, md_done;
   logic [XLEN-1:0] md_result;
   logic [XLEN-1:0] single_res;
   logic [SHW-1:0]  shamt;
   logic            div_by_zero;

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign result    = result_q;

   assign shamt       = op2[SHW-1:0];
   assign div_by_zero = is_div(op) && (op2 == '0);

   // Results that are known in the acceptance cycle. Divide-by-zero is
   // included here because it bypasses the iterative unit.
   always_comb begin
      single_res = '0;
      case (op)
         OP_ADD:  single_res = op1 + op2;
         OP_SUB:  single_res = op1 - op2;
         OP_SLL:  single_res = op1 << shamt;
         OP_SLT:  single_res[0] = $signed(op1) < $signed(op2);
         OP_SLTU: single_res[0] = op1 < op2;
         OP_XOR:  single_res = op1 ^ op2;
         OP_SRL:  single_res = op1 >> shamt;
         OP_SRA:  single_res = $signed(op1) >>> shamt;
         OP_OR:   single_res = op1 | op2;
         OP_AND:  single_res = op1 & op2;
         OP_DIV, OP_DIVU: single_res = '1;
         OP_REM, OP_REMU: single_res = op1;
         default: single_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      md_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               if (is_muldiv(op) && !div_by_zero) begin
                  md_start = 1'b1;
                  state_d  = ST_CALC;
               end else begin
                  result_d = single_res;
                  state_d  = ST_DONE;
               end
            end
         end
         ST_CALC: begin
            if (md_done) begin
               result_d = md_result;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
      end
   end

   alu_muldiv_iter #(
      .XLEN(XLEN)
   ) u_muldiv (
      .clk   (clk),
      .rst   (rst),
      .start (md_start),
      .op    (op),
      .op1   (op1),
      .op2   (op2),
      .done  (md_done),
      .result(md_result)
   );

endmodule

// File: tb/tb_alu_iter.sv
module tb_alu_iter;
   import alu_pkg::*;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   alu_op_t     op;
   logic [31:0] op1;
   logic [31:0] op2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] exp_q[$];

   typedef struct {
      alu_op_t     op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   alu_iter #(.XLEN(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .op       (op),
      .op1      (op1),
      .op2      (op2),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .busy     (busy)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual timeout required completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   // scoreboard: one expected value per accepted request, popped on handshake
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: actual %h required no output", result);
         end else begin
            check("result", result, exp_q.pop_front());
         end
      end
   end

   function automatic void add(alu_op_t o, logic [31:0] a, logic [31:0] b,
                               logic [31:0] e, int lat);
      vec_t v;
      v.op = o; v.a = a; v.b = b; v.exp = e; v.lat = lat;
      vecs.push_back(v);
   endfunction

   // driver: issue one request, scramble inputs after acceptance, check latency
   task automatic do_op(input string name, input alu_op_t o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e, input int lat);
      int n;
      @(negedge clk);
      out_ready = 1'b1;
      op        = o;
      op1       = a;
      op2       = b;
      in_valid  = 1'b1;
      exp_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      op       = OP_SUB;
      op1      = $urandom;
      op2      = $urandom;
      n = 1;
      while (!out_valid && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_latency"}, 32'(n), 32'(lat));
      @(posedge clk); #1;
      check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      int  ok;
      int  n;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op        = OP_ADD;
      op1       = '0;
      op2       = '0;

      add(OP_ADD,    32'd5,          32'd7,          32'd12,         1);
      add(OP_SUB,    32'd5,          32'd7,          32'hFFFFFFFE,   1);
      add(OP_SLL,    32'd1,          32'd35,         32'd8,          1);
      add(OP_SLT,    32'hFFFFFFFF,   32'd1,          32'd1,          1);
      add(OP_SLTU,   32'hFFFFFFFF,   32'd1,          32'd0,          1);
      add(OP_XOR,    32'hF0F0F0F0,   32'hFF00FF00,   32'h0FF00FF0,   1);
      add(OP_SRL,    32'h80000000,   32'd31,         32'd1,          1);
      add(OP_SRA,    32'h80000000,   32'd4,          32'hF8000000,   1);
      add(OP_OR,     32'h0000000F,   32'h000000F0,   32'h000000FF,   1);
      add(OP_AND,    32'h0000003C,   32'h0000000F,   32'h0000000C,   1);
      add(OP_MULH,   32'h80000000,   32'h80000000,   32'h40000000,   33);
      add(OP_MUL,    32'h80000000,   32'h80000000,   32'h00000000,   33);
      add(OP_MUL,    32'd12345,      32'd678,        32'd8369910,    33);
      add(OP_MUL,    32'hFFFFFFFD,   32'd5,          32'hFFFFFFF1,   33);
      add(OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   33);
      add(OP_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF,   33);
      add(OP_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000,   33);
      add(OP_DIV,    32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   33);
      add(OP_REM,    32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   33);
      add(OP_DIVU,   32'h80000000,   32'hFFFFFFFF,   32'h00000000,   33);
      add(OP_REMU,   32'd100,        32'd7,          32'd2,          33);
      add(OP_DIV,    32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   33);
      add(OP_REM,    32'd100,        32'hFFFFFFF9,   32'd2,          33);
      add(OP_DIVU,   32'd9,          32'd0,          32'hFFFFFFFF,   1);
      add(OP_REMU,   32'd9,          32'd0,          32'd9,          1);
      add(OP_DIV,    32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   1);
      add(OP_REM,    32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   1);
      add(OP_DIV,    32'h80000000,   32'hFFFFFFFF,   32'h80000000,   33);
      add(OP_REM,    32'h80000000,   32'hFFFFFFFF,   32'h00000000,   33);
      add(alu_op_t'(5'd31), 32'd123, 32'd456,        32'd0,          1);

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",  {31'd0, in_ready},  32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy",      {31'd0, busy},      32'd0);
      check("rst_result",    result,             32'd0);
      @(negedge clk);
      rst = 1'b0;

      // table-driven vectors
      for (int i = 0; i < vecs.size(); i++) begin
         do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
      end

      // backpressure: result held, in_valid ignored while in DONE
      @(negedge clk);
      out_ready = 1'b0;
      op  = OP_SRA;
      op1 = 32'hF0000000;
      op2 = 32'd36;
      in_valid = 1'b1;
      exp_q.push_back(32'hFF000000);
      @(posedge clk); #1;
      op  = OP_ADD;
      op1 = 32'd1;
      op2 = 32'd1;
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", {31'd0, out_valid}, 32'd1);
         check("bp_result",    result,             32'hFF000000);
         check("bp_in_ready",  {31'd0, in_ready},  32'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      @(posedge clk); #1;
      check("bp_release_in_ready",  {31'd0, in_ready},  32'd1);
      check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);

      // in_valid held high during CALC must be ignored
      @(negedge clk);
      op  = OP_MULHU;
      op1 = 32'hFFFFFFFF;
      op2 = 32'hFFFFFFFF;
      in_valid = 1'b1;
      exp_q.push_back(32'hFFFFFFFE);
      @(posedge clk); #1;
      op  = OP_ADD;
      op1 = 32'd1;
      op2 = 32'd1;
      ok = 1;
      for (int i = 0; i < 20; i++) begin
         if (in_ready !== 1'b0 || out_valid !== 1'b0) ok = 0;
         @(posedge clk); #1;
      end
      check("calc_ignore", 32'(ok), 32'd1);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("calc_ignore_done", {31'd0, out_valid}, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("calc_ignore_nothing_queued", {31'd0, out_valid}, 32'd0);

      // reset during CALC aborts the multiply
      @(negedge clk);
      op  = OP_MUL;
      op1 = 32'd3;
      op2 = 32'd4;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort_in_ready",  {31'd0, in_ready},  32'd1);
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_busy",      {31'd0, busy},      32'd0);
      check("abort_result",    result,             32'd0);
      @(negedge clk);
      rst = 1'b0;
      ok = 1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) ok = 0;
      end
      check("abort_no_stale", 32'(ok), 32'd1);
      do_op("after_abort_add", OP_ADD, 32'd1, 32'd1, 32'd2, 1);

      // reset while in DONE discards the result
      @(negedge clk);
      out_ready = 1'b0;
      op  = OP_ADD;
      op1 = 32'd3;
      op2 = 32'd3;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("done_rst_pre", {31'd0, out_valid}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("done_rst_out_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("done_rst_idle", {31'd0, in_ready}, 32'd1);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width (even, >= 8).
REQ-002 SHALL have localparam SHW = $clog2(XLEN), meaning shift-amount width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset; reset is asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, meaning the op/op1/op2 request is valid.
REQ-006 SHALL have port in_ready, output, 1, meaning the unit accepts a request this cycle.
REQ-007 SHALL have port op, input, alu_op_t (5 bits), meaning the operation selector from the decoder.
REQ-008 SHALL have ports op1 and op2, input, XLEN each, meaning the operands.
REQ-009 SHALL have port out_valid, output, 1, meaning result is valid.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-011 SHALL have port result, output, XLEN, meaning the registered operation result.
REQ-012 SHALL have port busy, output, 1, meaning the state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-014 Request SHALL be accepted on an edge with in_valid && in_ready; op and operands are captured into internal registers, so inputs may change afterwards.
REQ-015 Single-cycle ops ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND SHALL go IDLE->DONE; out_valid rises the cycle after acceptance (latency 1).
REQ-016 Shifts SHALL use op2[SHW-1:0] only; SRA sign-fills; SLT signed compare, SLTU unsigned, result 1 or 0 zero-extended; AND/OR/XOR bitwise.
REQ-017 Ops MUL, MULH, MULHSU, MULHU SHALL use an iterative shift-add on operand magnitudes, one bit per cycle, XLEN cycles in CALC, then sign-correct the 2*XLEN product; MUL returns low XLEN bits, MULH* high XLEN bits.
REQ-018 Ops DIV, DIVU, REM, REMU SHALL use restoring division on magnitudes, one quotient bit per cycle, XLEN cycles in CALC; quotient sign = op1 sign xor op2 sign, remainder sign = op1 sign (signed ops only).
REQ-019 Iterative ops SHALL go IDLE->CALC->DONE; out_valid rises exactly XLEN+1 cycles after acceptance; an internal counter of SHW+1 bits counts CALC cycles.
REQ-020 Divide by zero SHALL skip CALC (latency 1): DIV/DIVU result all-ones, REM/REMU result = op1.
REQ-021 Signed overflow (op1 = most-negative, op2 = -1) SHALL give DIV = op1 and REM = 0 with the normal iterative latency.
REQ-022 Unrecognised op codes SHALL complete with latency 1 and result 0.
REQ-023 In DONE, result SHALL hold stable until out_valid && out_ready; that edge returns state to IDLE; no new request is accepted in that same cycle.
REQ-024 in_valid asserted during CALC or DONE SHALL be ignored (in_ready low); no request is queued.

Reset
REQ-025 rst SHALL force state IDLE, result 0, counter 0, captured operands 0, hence in_ready 1, out_valid 0, busy 0.
REQ-026 rst asserted mid-CALC or in DONE SHALL abort the operation; the pending result is discarded and never presented.

Structure
REQ-027 alu_op_t enum (ADD..AND, MUL..REMU codes) and XLEN default SHALL live in shared package alu_pkg, used by decoder and alu_iter.
REQ-028 Iterative multiply/divide datapath SHALL be sub-module alu_muldiv_iter (start, op, operands in; done, result out), instantiated once; single-cycle ops stay in alu_iter.

Verification
REQ-029 ADD op1=5, op2=7, out_ready=1 -> out_valid one cycle after accept, result 12, then in_ready next cycle.
REQ-030 MULH op1=0x80000000, op2=0x80000000 (XLEN=32) -> out_valid 33 cycles after accept, result 0x40000000; MUL same operands -> 0.
REQ-031 DIV op1=-7, op2=2 -> result 0xFFFFFFFD (-3); REM same -> 0xFFFFFFFF (-1); DIVU 0x80000000 / 0xFFFFFFFF -> 0.
REQ-032 DIVU op1=9, op2=0 -> result 0xFFFFFFFF latency 1; REMU -> 9; DIV 0x80000000 by 0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-033 Backpressure: SRA op1=0xF0000000, op2=36 -> result 0xFF000000 held with out_ready=0 for 5 cycles, in_valid high ignored, completes on out_ready=1.
REQ-034 rst pulse at CALC cycle 10 of a MUL -> out_valid never rises for it, in_ready=1 after reset, next ADD 1+1 -> 2.
